// File: rtl/lib_sched_pkg.sv
// Shared types and helpers for the round-robin FIFO scheduler.
package lib_sched_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SERVE = 1'b1
    } state_e;

    localparam int unsigned STAT_W = 16;

    // Supports up to 32 requesters; callers slice the low N bits.
    function automatic logic [31:0] onehot(input int unsigned idx);
        logic [31:0] v;
        v = '0;
        v[idx[4:0]] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/lib_rr_pick.sv
// Combinational rotating-priority picker: first set request at or above i_ptr, modulo N.
module lib_rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    int unsigned cand;

    always_comb begin
        o_idx = '0;
        o_any = 1'b0;
        cand  = 0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = (32'(i_ptr) + i) % N;
            if (!o_any && i_req[cand[IW-1:0]]) begin
                o_idx = cand[IW-1:0];
                o_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lib_fifo_rr_sched.sv
// Round-robin scheduler popping N input FIFOs into one registered output stage with bursts.
// Optional per-requester pop counters when LIB_SCHED_STATS_EN is defined.
module lib_fifo_rr_sched
    import lib_sched_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned WIDTH = 4,
    parameter int unsigned BURST = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N*WIDTH-1:0] i_data,
    input  logic [N-1:0]       i_data_val,
    output logic [N-1:0]       o_en,
    output logic [WIDTH-1:0]   o_data,
    output logic               o_data_val,
    input  logic               i_en,
    output logic [N-1:0]       o_grant
`ifdef LIB_SCHED_STATS_EN
    ,
    output logic [N*STAT_W-1:0] o_grant_cnt
`endif
);

    localparam int unsigned IW = $clog2(N);
    localparam int unsigned BW = $clog2(BURST + 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             val_q, val_d;
    logic [N-1:0]     grant_q, grant_d;
    logic [IW-1:0]    gidx_q, gidx_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [BW-1:0]    bcnt_q, bcnt_d;

    logic [IW-1:0] pick_idx;
    logic          pick_any;
    logic [IW-1:0] sel;
    logic [31:0]   sel_oh;
    logic [31:0]   pick_oh;
    logic          load;
    logic          keep;
    logic          pop;

    lib_rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .i_req (i_data_val),
        .i_ptr (ptr_q),
        .o_idx (pick_idx),
        .o_any (pick_any)
    );

    always_comb begin
        load    = (state_q == ST_IDLE) || i_en;
        // Stay on the current grant only while it has data and burst budget remains.
        keep    = (state_q == ST_SERVE) && i_data_val[gidx_q] && (bcnt_q < BW'(BURST));
        pop     = !reset && load && (keep || pick_any);
        sel     = keep ? gidx_q : pick_idx;
        sel_oh  = onehot(32'(sel));
        pick_oh = onehot(32'(pick_idx));
        o_en    = pop ? sel_oh[N-1:0] : '0;

        state_d = state_q;
        data_d  = data_q;
        val_d   = val_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        bcnt_d  = bcnt_q;

        if (load) begin
            if (keep) begin
                data_d = i_data[32'(sel)*WIDTH +: WIDTH];
                bcnt_d = bcnt_q + BW'(1);
            end else if (pick_any) begin
                data_d  = i_data[32'(pick_idx)*WIDTH +: WIDTH];
                val_d   = 1'b1;
                grant_d = pick_oh[N-1:0];
                gidx_d  = pick_idx;
                bcnt_d  = BW'(1);
                state_d = ST_SERVE;
                if (pick_idx == IW'(N - 1)) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = pick_idx + IW'(1);
                end
            end else begin
                val_d   = 1'b0;
                grant_d = '0;
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            val_q   <= 1'b0;
            grant_q <= '0;
            gidx_q  <= '0;
            ptr_q   <= '0;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            val_q   <= val_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            bcnt_q  <= bcnt_d;
        end
    end

    assign o_data     = data_q;
    assign o_data_val = val_q;
    assign o_grant    = grant_q;

`ifdef LIB_SCHED_STATS_EN
    logic [N*STAT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        for (int unsigned i = 0; i < N; i++) begin
            if (o_en[i] && (cnt_q[i*STAT_W +: STAT_W] != {STAT_W{1'b1}})) begin
                cnt_d[i*STAT_W +: STAT_W] = cnt_q[i*STAT_W +: STAT_W] + STAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_grant_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_lib_fifo_rr_sched.sv
// Directed bench for lib_fifo_rr_sched: small FIFO models feed the inputs, expectations are fixed.
module tb_lib_fifo_rr_sched;

    logic        clk;
    logic        reset;
    logic [15:0] i_data;
    logic [3:0]  i_data_val;
    logic [3:0]  o_en;
    logic [3:0]  o_data;
    logic        o_data_val;
    logic        i_en;
    logic [3:0]  o_grant;

    logic [3:0]  fq [4][$];
    logic [3:0]  en_s;
    int          checks;
    int          failures;

    lib_fifo_rr_sched #(
        .N     (4),
        .WIDTH (4),
        .BURST (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_data     (i_data),
        .i_data_val (i_data_val),
        .o_en       (o_en),
        .o_data     (o_data),
        .o_data_val (o_data_val),
        .i_en       (i_en),
        .o_grant    (o_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int p = 0; p < 4; p++) begin
            i_data_val[p] = (fq[p].size() != 0);
            i_data[p*4 +: 4] = (fq[p].size() != 0) ? fq[p][0] : 4'h0;
        end
    endtask

    // One clock: capture the pop strobes seen by the edge, then advance the FIFO models.
    task automatic tick();
        @(negedge clk);
        en_s = o_en;
        @(posedge clk);
        #1;
        for (int p = 0; p < 4; p++) begin
            if (en_s[p] && fq[p].size() != 0) void'(fq[p].pop_front());
        end
        drive();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int p = 0; p < 4; p++) fq[p].delete();
        drive();
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    int          gexp [10];
    logic [3:0]  dexp [10];

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        i_en     = 1'b0;
        i_data   = '0;
        i_data_val = '0;

        // Reset with every requester valid: nothing may be popped or granted.
        for (int p = 0; p < 4; p++) fq[p].push_back(4'(p + 1));
        drive();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_en", 32'(o_en), 32'h0);
            check("rst_val", 32'(o_data_val), 32'h0);
            check("rst_grant", 32'(o_grant), 32'h0);
        end
        for (int p = 0; p < 4; p++) fq[p].delete();
        drive();
        reset = 1'b0;
        tick();

        // Single requester streams D,E,A back-to-back.
        i_en = 1'b1;
        fq[1].push_back(4'hD);
        fq[1].push_back(4'hE);
        fq[1].push_back(4'hA);
        drive();
        #1;
        check("t2_en_idle", 32'(o_en), 32'h2);
        tick();
        check("t2_data0", 32'(o_data), 32'hD);
        check("t2_val0", 32'(o_data_val), 32'h1);
        check("t2_grant0", 32'(o_grant), 32'h2);
        check("t2_en0", 32'(o_en), 32'h2);
        tick();
        check("t2_data1", 32'(o_data), 32'hE);
        check("t2_en1", 32'(o_en), 32'h2);
        tick();
        check("t2_data2", 32'(o_data), 32'hA);
        check("t2_grant2", 32'(o_grant), 32'h2);
        check("t2_en2", 32'(o_en), 32'h0);
        tick();
        check("t2_val_end", 32'(o_data_val), 32'h0);
        check("t2_grant_end", 32'(o_grant), 32'h0);

        // Fairness with bursts of two across four always-valid requesters.
        do_reset();
        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < 6; k++) fq[p].push_back(4'(p * 4 + k));
        end
        drive();
        gexp = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
        dexp = '{4'h0, 4'h1, 4'h4, 4'h5, 4'h8, 4'h9, 4'hC, 4'hD, 4'h2, 4'h3};
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("t3_grant%0d", i), 32'(o_grant), 32'h1 << gexp[i]);
            check($sformatf("t3_data%0d", i), 32'(o_data), 32'(dexp[i]));
        end

        // Backpressure holds the registered flit.
        do_reset();
        fq[0].push_back(4'hB);
        fq[0].push_back(4'hC);
        drive();
        tick();
        check("t4_data_b", 32'(o_data), 32'hB);
        i_en = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("t4_hold_data%0d", i), 32'(o_data), 32'hB);
            check($sformatf("t4_hold_val%0d", i), 32'(o_data_val), 32'h1);
            check($sformatf("t4_hold_en%0d", i), 32'(o_en), 32'h0);
        end
        i_en = 1'b1;
        #1;
        check("t4_release_en", 32'(o_en), 32'h1);
        tick();
        check("t4_data_c", 32'(o_data), 32'hC);
        tick();
        check("t4_val_end", 32'(o_data_val), 32'h0);

        // Sole requester keeps flowing across burst boundaries.
        do_reset();
        for (int k = 1; k <= 4; k++) fq[2].push_back(4'(k));
        drive();
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("t5_data%0d", k), 32'(o_data), 32'(k));
            check($sformatf("t5_grant%0d", k), 32'(o_grant), 32'h4);
            check($sformatf("t5_en%0d", k), 32'(o_en), (k < 4) ? 32'h4 : 32'h0);
        end
        tick();
        check("t5_val_end", 32'(o_data_val), 32'h0);

        // Reset while serving drops the flit and restarts the pointer at 0.
        do_reset();
        fq[3].push_back(4'h5);
        fq[3].push_back(4'h6);
        fq[3].push_back(4'h7);
        fq[1].push_back(4'h9);
        drive();
        tick();
        check("t6_grant_pre", 32'(o_grant), 32'h2);
        check("t6_data_pre", 32'(o_data), 32'h9);
        reset = 1'b1;
        #1;
        check("t6_en_in_rst", 32'(o_en), 32'h0);
        tick();
        check("t6_val_rst", 32'(o_data_val), 32'h0);
        check("t6_grant_rst", 32'(o_grant), 32'h0);
        fq[1].push_back(4'hA);
        drive();
        reset = 1'b0;
        #1;
        check("t6_en_after", 32'(o_en), 32'h2);
        tick();
        check("t6_grant_after", 32'(o_grant), 32'h2);
        check("t6_data_after", 32'(o_data), 32'hA);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lib_fifo_rr_sched.md
Name: lib_fifo_rr_sched

Overview:
Round-robin scheduler that shares one downstream output among N LIB_FIFO-style input buffers.
- Each input presents a head flit plus a head-valid.
- The block pops the granted FIFO and registers the flit into a single output stage.
- The output stage uses the same valid/enable handshake as the buffers.
- Sits between a bank of per-port input FIFOs and a shared link or output port in the emulated network.

Parameters:
N, 4, number of requesting FIFOs (>=2)
WIDTH, 4, flit width in bits
BURST, 2, max consecutive flits served from one requester before grant rotates (>=1)

Ports:
clk  in  1  system clock, all logic rising-edge
reset  in  1  synchronous, active-high reset
i_data  in  N x WIDTH  head flit of each FIFO (FIFO o_data)
i_data_val  in  N  head-valid of each FIFO (FIFO o_data_val)
o_en  out  N  pop strobe per FIFO (drives FIFO i_en); at most one bit high
o_data  out  WIDTH  registered scheduled flit
o_data_val  out  1  o_data holds an unconsumed flit
i_en  in  1  downstream consumed o_data this cycle
o_grant  out  N  one-hot current grant, 0 when idle

Behaviour:
- One clock domain; reset is synchronous and active-high, sampled on rising clk.
- Reset values:
  - o_data=0, o_data_val=0, o_grant=0, o_en=0.
  - rr_ptr=0, burst_cnt=0, state=IDLE.
  - o_en is forced to 0 while reset is high, regardless of i_data_val.
- States IDLE, SERVE.
- Load slot: a cycle where state==IDLE, or state==SERVE with i_en=1. o_en and the grant choice are combinational; register updates occur on the next edge.
- Pick: first requester with i_data_val=1, searching from rr_ptr upward modulo N.
- IDLE:
  - No valid requester: stay IDLE, outputs unchanged (o_data_val=0).
  - Otherwise pick g: o_en[g]=1 this cycle.
  - Next edge: o_data<=i_data[g], o_data_val<=1, o_grant<=onehot(g), burst_cnt<=1, rr_ptr<=(g+1) mod N, state<=SERVE.
- SERVE, i_en=0: hold o_data, o_data_val, o_grant; o_en=0. Backpressure is indefinite.
- SERVE, i_en=1, first match wins:
  1. Current grant g still valid and burst_cnt<BURST: pop g, load its head, burst_cnt++. rr_ptr is unchanged (it already holds g+1).
  2. Otherwise, any requester valid: pick from rr_ptr, load it, burst_cnt<=1, rr_ptr<=pick+1.
     - If g is the only valid requester, it is re-granted (work-conserving).
  3. Otherwise: o_data_val<=0, o_grant<=0, state<=IDLE.
- Throughput: one flit per cycle while i_en stays high and requesters stay valid.
  - A FIFO's head updates the cycle after its pop, so the next i_data_val sample is always fresh.
- Latency: head valid in IDLE at cycle t gives o_data_val=1 at t+1.
- i_en=1 while o_data_val=0: ignored.
- rr_ptr wraps N-1 -> 0. burst_cnt width is clog2(BURST+1).
- Reset mid-SERVE: the registered flit is discarded. It was already popped and is lost; this is accepted behaviour.
- i_data of non-valid requesters is don't-care.

Optional Feature:
LIB_SCHED_STATS_EN:
- Defined:
  - Adds output o_grant_cnt, N x 16, one counter per requester.
  - A counter increments on each pop of its requester and saturates at 16'hFFFF.
  - Cleared by reset.
- Undefined: the port and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package lib_sched_pkg:
  - state enum typedef (IDLE, SERVE);
  - STAT_W=16 constant;
  - onehot-from-index function.
- One sub-module, lib_rr_pick: combinational N-way rotating priority picker.
  - Inputs: request vector, rr_ptr.
  - Outputs: pick index, any-valid.
- Top holds the FSM, burst counter, output register and stats.

Test Plan:
1. Reset: reset=1 for 3 cycles with i_data_val=4'b1111 -> o_en=0, o_data_val=0, o_grant=0 throughout.
2. Single requester: FIFO1 holds D,E,A; i_en=1 constantly -> o_data D,E,A on consecutive cycles; o_grant=0010; o_en[1] pulses 3 times; then o_data_val=0, IDLE.
3. Fairness/burst: all 4 requesters continuously valid, i_en=1 -> grant sequence 0,0,1,1,2,2,3,3,0,0.
4. Backpressure: while o_data=B, hold i_en=0 for 5 cycles -> o_data stays B, o_en=0; i_en=1 -> next flit the following cycle.
5. Sole requester past burst: only FIFO2 valid with 4 flits -> all 4 flits issued back-to-back; burst_cnt restarts at 1 after 2 flits.
6. Reset mid-SERVE: assert reset while o_data_val=1 -> next edge o_data_val=0, o_grant=0; after release, first grant goes to the lowest-index valid requester (rr_ptr=0).
